// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester a tenure of up to BURST_MAX
// words into a downstream synchronous FIFO, one arbitration cycle per tenure.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 32,
  parameter int NREQ      = 4,
  parameter int BURST_MAX = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*WIDTH-1:0]   wdata_i,
  input  logic                    fifo_full_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic                    fifo_we_o,
  output logic [WIDTH-1:0]        fifo_wdata_o,
  output logic [$clog2(NREQ)-1:0] owner_o,
  output logic                    busy_o
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST_MAX + 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   scan_idx;
  logic            found;
  logic [WIDTH-1:0] words [NREQ];

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      words[k] = wdata_i[k*WIDTH +: WIDTH];
    end
  end

  // Search upward from rr_ptr; the IW-bit add wraps because NREQ is a power of two.
  always_comb begin
    pick_idx = rr_ptr_q;
    scan_idx = rr_ptr_q;
    found    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = rr_ptr_q + IW'(i);
      if (!found && req_i[scan_idx]) begin
        pick_idx = scan_idx;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (rst_ni && state_q == BURST) begin
      gnt_o[owner_q] = req_i[owner_q] & ~fifo_full_i;
    end
    fifo_we_o    = |gnt_o;
    fifo_wdata_o = fifo_we_o ? words[owner_q] : '0;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (!req_i[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = owner_q + IW'(1);
        end else if (fifo_we_o) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(BURST_MAX)) begin
            state_d  = IDLE;
            rr_ptr_d = owner_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy_o  = (state_q == BURST);
  assign owner_o = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle output checks plus a write
// scoreboard that a monitor drains whenever the FIFO write enable is seen.
module tb_fifo_wr_arbiter;

  localparam int WIDTH     = 32;
  localparam int NREQ      = 4;
  localparam int BURST_MAX = 4;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [NREQ-1:0]       req_i;
  logic [NREQ*WIDTH-1:0] wdata_i;
  logic                  fifo_full_i;
  logic [NREQ-1:0]       gnt_o;
  logic                  fifo_we_o;
  logic [WIDTH-1:0]      fifo_wdata_o;
  logic [1:0]            owner_o;
  logic                  busy_o;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int srcIdx [NREQ];
  int expIdx [NREQ];
  logic [NREQ+WIDTH-1:0] expQ [$];

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST_MAX(BURST_MAX)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .wdata_i      (wdata_i),
    .fifo_full_i  (fifo_full_i),
    .gnt_o        (gnt_o),
    .fifo_we_o    (fifo_we_o),
    .fifo_wdata_o (fifo_wdata_o),
    .owner_o      (owner_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [WIDTH-1:0] wordOf(input int k, input int n);
    return 32'hD000_0000 | WIDTH'(k << 8) | WIDTH'(n & 8'hFF);
  endfunction

  // Each requester presents its next word and advances only once it is accepted.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      wdata_i[k*WIDTH +: WIDTH] = wordOf(k, srcIdx[k]);
    end
  end

  always @(posedge clk_i) begin
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_o[k] === 1'b1) srcIdx[k] <= srcIdx[k] + 1;
    end
  end

  always @(negedge clk_i) begin
    #2;
    if (fifo_we_o === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write cycle %0d: got data %h gnt %b, expected no write", cycle, fifo_wdata_o, gnt_o);
      end else begin
        logic [NREQ+WIDTH-1:0] e;
        e = expQ.pop_front();
        if (fifo_wdata_o !== e[WIDTH-1:0] || gnt_o !== e[NREQ+WIDTH-1:WIDTH]) begin
          errors++;
          $display("[TB] FAIL write_data cycle %0d: got gnt %b data %h, expected gnt %b data %h",
                   cycle, gnt_o, fifo_wdata_o, e[NREQ+WIDTH-1:WIDTH], e[WIDTH-1:0]);
        end
      end
    end
  end

  task automatic checkOutput(input logic [NREQ-1:0] eGnt, input logic eBusy, input logic [1:0] eOwner);
    checks++;
    if (gnt_o !== eGnt) begin
      errors++;
      $display("[TB] FAIL gnt cycle %0d: got %b expected %b", cycle, gnt_o, eGnt);
    end
    checks++;
    if (fifo_we_o !== (|eGnt)) begin
      errors++;
      $display("[TB] FAIL fifo_we cycle %0d: got %b expected %b", cycle, fifo_we_o, |eGnt);
    end
    checks++;
    if (busy_o !== eBusy) begin
      errors++;
      $display("[TB] FAIL busy cycle %0d: got %b expected %b", cycle, busy_o, eBusy);
    end
    checks++;
    if (owner_o !== eOwner) begin
      errors++;
      $display("[TB] FAIL owner cycle %0d: got %0d expected %0d", cycle, owner_o, eOwner);
    end
    if (eGnt == '0) begin
      checks++;
      if (fifo_wdata_o !== '0) begin
        errors++;
        $display("[TB] FAIL idle_wdata cycle %0d: got %h expected 0", cycle, fifo_wdata_o);
      end
    end
  endtask

  task automatic applyStimulus(input logic rstn, input logic [NREQ-1:0] req, input logic full,
                               input logic [NREQ-1:0] eGnt, input logic eBusy,
                               input logic [1:0] eOwner, input int reps);
    for (int r = 0; r < reps; r++) begin
      @(negedge clk_i);
      cycle++;
      rst_ni      = rstn;
      req_i       = req;
      fifo_full_i = full;
      #1;
      for (int k = 0; k < NREQ; k++) begin
        if (eGnt[k]) begin
          expQ.push_back({eGnt, wordOf(k, expIdx[k])});
          expIdx[k]++;
        end
      end
      checkOutput(eGnt, eBusy, eOwner);
    end
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      srcIdx[k] = 0;
      expIdx[k] = 0;
    end
    rst_ni      = 1'b0;
    req_i       = '0;
    fifo_full_i = 1'b0;
    repeat (2) @(posedge clk_i);

    // Reset with every requester asserted
    applyStimulus(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 2);

    // All requesting: tenures rotate 0,1,2,3,0 with one arbitration cycle each
    applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1);
    applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 4);
    applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1);
    applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 4);
    applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd1, 1);
    applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2, 4);
    applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd2, 1);
    applyStimulus(1'b1, 4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, 4);
    applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd3, 1);
    applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 4);
    applyStimulus(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1);

    // Lone requester 0 with six words: 1 idle, 4 writes, 1 idle, 2 writes
    applyStimulus(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0, 1);
    applyStimulus(1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 4);
    applyStimulus(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0, 1);
    applyStimulus(1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 2);
    applyStimulus(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 1);
    applyStimulus(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1);

    // Owner 2 stalled by a full FIFO for three cycles after its second word
    applyStimulus(1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, 1);
    applyStimulus(1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 2);
    applyStimulus(1'b1, 4'b0100, 1'b1, 4'b0000, 1'b1, 2'd2, 3);
    applyStimulus(1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 2);
    applyStimulus(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1);

    // Owner 1 drops after two words; pending requester 3 wins next, not 0
    applyStimulus(1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 2'd2, 1);
    applyStimulus(1'b1, 4'b1011, 1'b0, 4'b0010, 1'b1, 2'd1, 2);
    applyStimulus(1'b1, 4'b1001, 1'b0, 4'b0000, 1'b1, 2'd1, 1);
    applyStimulus(1'b1, 4'b1001, 1'b0, 4'b0000, 1'b0, 2'd1, 1);
    applyStimulus(1'b1, 4'b1001, 1'b0, 4'b1000, 1'b1, 2'd3, 1);

    // Reset lands on owner 3's second word; afterwards requester 0 wins
    applyStimulus(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3, 1);
    applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1);
    applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 1);
    applyStimulus(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 1);
    applyStimulus(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1);

    @(negedge clk_i);
    #5;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_writes: got %0d words still pending, expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data word width.
REQ-002 The block SHALL have parameter NREQ, default 4, number of requesters (power of two, >=2).
REQ-003 The block SHALL have parameter BURST_MAX, default 4, maximum words per grant tenure (>=1).
REQ-004 The block SHALL have port clk_i  input  1  single clock; all state updates on posedge.
REQ-005 The block SHALL have port rst_ni  input  1  synchronous active-low reset.
REQ-006 The block SHALL have port req_i  input  NREQ  per-requester write request, bit k = requester k.
REQ-007 The block SHALL have port wdata_i  input  NREQ*WIDTH  requester k data in bits [k*WIDTH +: WIDTH].
REQ-008 The block SHALL have port fifo_full_i  input  1  full flag from the downstream sync FIFO.
REQ-009 The block SHALL have port gnt_o  output  NREQ  one-hot accept; gnt_o[k]=1 means requester k's word is written this cycle.
REQ-010 The block SHALL have port fifo_we_o  output  1  FIFO write enable.
REQ-011 The block SHALL have port fifo_wdata_o  output  WIDTH  FIFO write data.
REQ-012 The block SHALL have port owner_o  output  $clog2(NREQ)  index of current tenure owner.
REQ-013 The block SHALL have port busy_o  output  1  high while a tenure (BURST state) is active.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE and BURST.
REQ-015 In IDLE with req_i != 0, the block SHALL pick the first set bit of req_i searching upward from rr_ptr with wrap at NREQ, latch it into owner, clear the burst counter, and enter BURST next cycle.
REQ-016 In IDLE, gnt_o SHALL be zero, so a tenure costs exactly one arbitration cycle before the first transfer.
REQ-017 In IDLE with req_i == 0, the block SHALL remain in IDLE with owner and rr_ptr unchanged.
REQ-018 In BURST, gnt_o[owner] SHALL equal req_i[owner] & ~fifo_full_i combinationally, and all other gnt_o bits SHALL be 0.
REQ-019 fifo_we_o SHALL equal |gnt_o; fifo_wdata_o SHALL equal the owner's wdata_i slice when fifo_we_o=1, else all zeros.
REQ-020 Each BURST cycle with fifo_we_o=1 SHALL increment the burst counter (width $clog2(BURST_MAX+1)).
REQ-021 BURST SHALL exit to IDLE after the transfer that brings the count to BURST_MAX.
REQ-022 BURST SHALL exit to IDLE in any cycle where req_i[owner]=0.
REQ-023 With fifo_full_i=1 and req_i[owner]=1, the block SHALL stay in BURST with the counter held and no write.
REQ-024 On every BURST->IDLE exit, rr_ptr SHALL become (owner+1) mod NREQ; it SHALL not change otherwise.
REQ-025 Requests from non-owners during BURST SHALL be ignored until the next IDLE arbitration.
REQ-026 busy_o SHALL be 1 exactly in BURST; owner_o SHALL reflect the owner register at all times.
REQ-027 The block SHALL never write while fifo_full_i=1, so FIFO overflow is impossible.

Reset
REQ-028 While rst_ni=0, gnt_o, fifo_we_o and fifo_wdata_o SHALL be forced to 0 combinationally.
REQ-029 On a clock edge with rst_ni=0, state SHALL become IDLE, rr_ptr=0, owner=0 and counter=0, giving busy_o=0 and owner_o=0.
REQ-030 Reset asserted mid-BURST SHALL abandon the tenure with no partial write and no rr_ptr update.

Verification
REQ-031 Reset: hold rst_ni=0 for 2 cycles with req_i=4'b1111 -> gnt_o=0, fifo_we_o=0, busy_o=0, owner_o=0 throughout.
REQ-032 Single requester 0 holding req for 6 words with BURST_MAX=4 -> timeline is 1 idle, 4 writes, 1 idle, 2 writes; data order is preserved.
REQ-033 req_i=4'b1111 held -> tenures are granted to owners 0,1,2,3,0 in that order, each 4 words, separated by 1 idle cycle.
REQ-034 fifo_full_i=1 for 3 cycles after owner 2's second word -> gnt_o=0 and busy_o=1 for those 3 cycles, then words 3-4 are written and the tenure ends.
REQ-035 Owner 1 drops req after 2 words while req_i[3] is pending -> IDLE next cycle, rr_ptr=2, and the next tenure goes to owner 3.
REQ-036 rst_ni=0 during owner 3's second word -> fifo_we_o=0 in that cycle; after reset, with all requests asserted, owner 0 wins.
